// File: rtl/let_fmod.sv
// Sequential signed floored-modulo unit: quot = floor(a/b), rem = a - b*quot.
// Restoring shift-subtract divider on magnitudes, then a sign/floor fix-up cycle.
module let_fmod #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] ub;
    logic [WIDTH-1:0] pr;
    logic [WIDTH-1:0] fix_q;
    logic [WIDTH-1:0] fix_r;
    logic             fix_dz;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] qt;
    logic [WIDTH-1:0] rt;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    // Magnitudes as unsigned; the most negative value maps onto 2^(WIDTH-1).
    assign abs_a = a[WIDTH-1] ? -a : a;
    assign abs_b = b[WIDTH-1] ? -b : b;

    // The trial value is one bit wider than the divisor; after a successful
    // subtract the difference is below ub, so WIDTH bits suffice to keep it.
    assign shifted = {pr, dvd[WIDTH-1]};
    assign ge      = shifted >= {1'b0, ub};
    assign diff    = shifted[WIDTH-1:0] - ub;

    assign a_neg = a_reg[WIDTH-1];
    assign b_neg = b_reg[WIDTH-1];

    always_comb begin
        qt      = (a_neg ^ b_neg) ? -dvd : dvd;
        rt      = a_neg ? -pr : pr;
        q_final = qt;
        r_final = rt;
        if ((rt != '0) && (rt[WIDTH-1] != b_neg)) begin
            q_final = qt - 1'b1;
            r_final = rt + b_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            dvd         <= '0;
            ub          <= '0;
            pr          <= '0;
            fix_q       <= '0;
            fix_r       <= '0;
            fix_dz      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        dvd   <= abs_a;
                        ub    <= abs_b;
                        pr    <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    pr  <= ge ? diff : shifted[WIDTH-1:0];
                    dvd <= {dvd[WIDTH-2:0], ge};
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                FIX: begin
                    // A zero divisor bypasses the divider result entirely.
                    if (b_reg == '0) begin
                        fix_q  <= '0;
                        fix_r  <= a_reg;
                        fix_dz <= 1'b1;
                    end else begin
                        fix_q  <= q_final;
                        fix_r  <= r_final;
                        fix_dz <= 1'b0;
                    end
                    state <= DONE;
                end
                DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    quot        <= fix_q;
                    rem         <= fix_r;
                    div_by_zero <= fix_dz;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_let_fmod.sv
// Self-checking bench for let_fmod: directed sign/edge cases, random operands
// against an integer floor-division model, back-to-back requests and reset.
module tb_let_fmod;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;
    logic        div_by_zero;

    int assertCount = 0;
    int failCount   = 0;

    let_fmod #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .quot       (quot),
        .rem        (rem),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Floor division from plain 64-bit integer arithmetic, wrapped to 32 bits.
    function automatic void refFmod(input logic [31:0] opA, input logic [31:0] opB,
                                    output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint la;
        longint lb;
        longint lq;
        longint lr;
        la = longint'($signed(opA));
        lb = longint'($signed(opB));
        if (lb == 0) begin
            q  = 32'd0;
            r  = opA;
            dz = 1'b1;
        end else begin
            lq = la / lb;
            if ((lq * lb != la) && ((la < 0) != (lb < 0))) lq = lq - 1;
            lr = la - lq * lb;
            q  = lq[31:0];
            r  = lr[31:0];
            dz = 1'b0;
        end
    endfunction

    task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                                 input logic [31:0] expQ, input logic [31:0] expR,
                                 input logic expDz, input string tag);
        int edges;
        int busyLow;
        @(negedge clk);
        start = 1'b1;
        a     = opA;
        b     = opB;
        @(posedge clk);
        #1;
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        edges   = 0;
        busyLow = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (!done) begin
                if (!busy) busyLow++;
                start = 1'($urandom_range(0, 1));
            end
        end
        start = 1'b0;
        checkOutput($sformatf("%s latency", tag), 64'(edges), 64'd34);
        checkOutput($sformatf("%s busy held", tag), 64'(busyLow), 64'd0);
        checkOutput($sformatf("%s quot", tag), 64'(quot), 64'(expQ));
        checkOutput($sformatf("%s rem", tag), 64'(rem), 64'(expR));
        checkOutput($sformatf("%s dbz", tag), 64'(div_by_zero), 64'(expDz));
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s done pulse", tag), 64'(done), 64'd0);
        checkOutput($sformatf("%s idle after", tag), 64'(busy), 64'd0);
    endtask

    task automatic randomOp(input int idx);
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        opA = $urandom;
        case ($urandom_range(0, 4))
            0: opB = 32'd0;
            1: opB = 32'($urandom_range(1, 200));
            2: opB = -32'($urandom_range(1, 200));
            default: opB = $urandom;
        endcase
        if ($urandom_range(0, 5) == 0) opA = 32'd0;
        refFmod(opA, opB, q, r, dz);
        applyStimulus(opA, opB, q, r, dz, $sformatf("rand%0d", idx));
    endtask

    logic [31:0] dirA [10];
    logic [31:0] dirB [10];
    logic [31:0] dirQ [10];
    logic [31:0] dirR [10];
    logic        dirZ [10];

    initial begin
        logic [31:0] qa [$];
        logic [31:0] qb [$];
        logic [31:0] eq;
        logic [31:0] er;
        logic [31:0] pa;
        logic [31:0] pb;
        logic        ez;
        logic        wasIdle;
        int          accepted;
        int          dones;
        int          stray;

        dirA = '{32'd7, -32'd7, 32'd7, -32'd7, -32'd6, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'd399, -32'd1};
        dirB = '{32'd3, 32'd3, -32'd3, -32'd3, 32'd3, -32'd1, 32'd1, 32'd0, 32'd100, 32'd100};
        dirQ = '{32'd2, -32'd3, -32'd3, 32'd2, -32'd2, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd3, -32'd1};
        dirR = '{32'd1, 32'd2, -32'd2, -32'd1, 32'd0, 32'd0, 32'd0, 32'd5, 32'd99, 32'd99};
        dirZ = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset done", 64'(done), 64'd0);
        checkOutput("reset quot", 64'(quot), 64'd0);
        checkOutput("reset rem", 64'(rem), 64'd0);
        checkOutput("reset dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(dirA[i], dirB[i], dirQ[i], dirR[i], dirZ[i], $sformatf("dir%0d", i));
        end

        for (int i = 0; i < 24; i++) begin
            randomOp(i);
        end

        // Start held high: only requests seen while idle may be accepted.
        accepted = 0;
        dones    = 0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            start   = 1'b1;
            a       = $urandom;
            b       = (c % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
            wasIdle = !busy;
            @(posedge clk);
            if (wasIdle) begin
                qa.push_back(a);
                qb.push_back(b);
                accepted++;
            end
            #1;
            if (done) begin
                dones++;
                if (qa.size() > 0) begin
                    pa = qa.pop_front();
                    pb = qb.pop_front();
                    refFmod(pa, pb, eq, er, ez);
                    checkOutput("b2b quot", 64'(quot), 64'(eq));
                    checkOutput("b2b rem", 64'(rem), 64'(er));
                    checkOutput("b2b dbz", 64'(div_by_zero), 64'(ez));
                end else begin
                    checkOutput("b2b spurious done", 64'd1, 64'd0);
                end
            end
        end
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && dones < accepted; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (qa.size() > 0) begin
                    pa = qa.pop_front();
                    pb = qb.pop_front();
                    refFmod(pa, pb, eq, er, ez);
                    checkOutput("b2b tail quot", 64'(quot), 64'(eq));
                    checkOutput("b2b tail rem", 64'(rem), 64'(er));
                end
            end
        end
        checkOutput("b2b accepted", 64'(accepted), 64'd5);
        checkOutput("b2b done count", 64'(dones), 64'(accepted));

        // Make the outputs non-zero so the reset clearing is observable.
        applyStimulus(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "pre-reset");
        @(negedge clk);
        start = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst busy", 64'(busy), 64'd0);
        checkOutput("midrst done", 64'(done), 64'd0);
        checkOutput("midrst quot", 64'(quot), 64'd0);
        checkOutput("midrst rem", 64'(rem), 64'd0);
        checkOutput("midrst dbz", 64'(div_by_zero), 64'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        stray = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (done) stray++;
        end
        checkOutput("midrst no done", 64'(stray), 64'd0);
        applyStimulus(32'd9, 32'd4, 32'd2, 32'd1, 1'b0, "post-reset");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/let_fmod.md
Name: let_fmod

Overview:
- Sequential signed floored-modulo unit: rem = a − b·floor(a/b), quot = floor(a/b).
- Integer hardware counterpart of the fmod helper used by the PLL phase/timing models, e.g. for phase wrap modulo the reference period or modulo the divider ratio.
- Iterative shift-subtract divider with a start/done handshake. One operation in flight at a time.

Parameters:
- WIDTH, 32, operand/result width in bits, two's-complement signed, ≥ 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request. Sampled only when busy=0.
- a  in  WIDTH  signed dividend. Captured on the accepting edge.
- b  in  WIDTH  signed divisor. Captured on the accepting edge.
- busy  out  1  high from the accepting edge until done is asserted.
- done  out  1  single-cycle pulse; results valid.
- quot  out  WIDTH  signed floor(a/b).
- rem  out  WIDTH  signed floored remainder. Sign follows b; |rem| < |b|.
- div_by_zero  out  1  b was 0 for the reported result.

Behaviour:
- Reset (async assert, sync release):
  - busy=0, done=0, quot=0, rem=0, div_by_zero=0.
  - State = IDLE.
  - Any in-flight operation is discarded; no done is produced for it.
- States:
  - IDLE: if start=1, latch a and b, form |a| and |b| as WIDTH-bit unsigned (|−2^(W−1)| = 2^(W−1)), record sign(a) and sign(b), set busy=1, go to CALC.
  - CALC: WIDTH iterations of restoring unsigned division, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits.
  - FIX (1 cycle): apply signs and floor correction, then go to DONE.
  - DONE: drive done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: done is high in the cycle following the (WIDTH+2)th rising edge after the edge that sampled start.
- Throughput: a new start is accepted in the cycle after done. The next operation may be accepted on the same edge where done deasserts.
- Sign/floor rules in FIX, with unsigned results uq and ur:
  - Truncated quotient: qt = uq negated if sign(a)≠sign(b).
  - Truncated remainder: rt = ur negated if a<0.
  - If rt≠0 and sign(rt)≠sign(b): quot = qt − 1, rem = rt + b.
  - Otherwise: quot = qt, rem = rt.
  - All arithmetic is modulo 2^WIDTH.
- Overflow: a = −2^(W−1), b = −1 → quot wraps to −2^(W−1), rem = 0, no flag.
- Divide by zero (b=0): div_by_zero=1, quot=0, rem=a, same latency as a normal operation.
- quot, rem and div_by_zero hold their last values until the next done or reset. They update only on the edge that asserts done.
- start while busy=1 is ignored: not queued, and does not disturb the operation in flight.
- Operand changes after acceptance have no effect.
- a=0 → quot=0, rem=0 for any b≠0.

Test Plan:
- WIDTH=32. a=7, b=3 → quot=2, rem=1, div_by_zero=0. done exactly 34 edges after the start edge; busy high throughout.
- Sign quadrants:
  - a=−7, b=3 → quot=−3, rem=2.
  - a=7, b=−3 → quot=−3, rem=−2.
  - a=−7, b=−3 → quot=2, rem=−1.
  - a=−6, b=3 → quot=−2, rem=0.
- Edge values:
  - a=−2^31, b=−1 → quot=−2^31, rem=0.
  - a=−2^31, b=1 → quot=−2^31, rem=0.
  - a=5, b=0 → div_by_zero=1, quot=0, rem=5.
- Phase-wrap use: a=399 (tau in ps), b=100 → quot=3, rem=99. a=−1, b=100 → quot=−1, rem=99.
- Back-to-back: start held high continuously with changing operands → each result matches the operands sampled when busy=0. Requests raised mid-operation are dropped. Exactly one done per accepted request.
- Reset mid-operation: assert rst 10 cycles after start → all outputs 0 immediately (asynchronous), no done. A fresh start afterwards (a=9, b=4) → quot=2, rem=1.
